// File: rtl/hub75_scan_ctrl.sv
// HUB75 row-scan sequencer: preload, wait, swap+paint per row over a run-time row window,
// linear or interleaved order, with looping, graceful stop and frame accounting.
module hub75_scan_ctrl #(
  parameter int unsigned N_ROWS      = 32,
  parameter int unsigned LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int unsigned FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LOG_N_ROWS-1:0]  cfg_row_first,
  input  logic [LOG_N_ROWS-1:0]  cfg_row_last,
  input  logic                   cfg_interleave,
  input  logic                   cfg_loop,
  input  logic                   ctrl_go,
  input  logic                   ctrl_stop,
  output logic                   ctrl_rdy,
  output logic                   cfg_err,
  output logic [LOG_N_ROWS-1:0]  bcm_row,
  output logic                   bcm_go,
  input  logic                   bcm_rdy,
  output logic [LOG_N_ROWS-1:0]  fb_row_addr,
  output logic                   fb_row_load,
  input  logic                   fb_row_rdy,
  output logic                   fb_row_swap,
  output logic                   frame_start,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned RW = LOG_N_ROWS;
  localparam int unsigned EW = LOG_N_ROWS + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_PAINT = 2'd3;

  logic [1:0]             r_state;
  logic [RW-1:0]          r_row;
  logic                   r_phase;
  logic [RW-1:0]          r_first;
  logic [RW-1:0]          r_last;
  logic                   r_il;
  logic                   r_loop;
  logic                   r_stop_pend;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   r_ctrl_rdy;
  logic                   r_cfg_err;
  logic                   r_bcm_go;
  logic                   r_fb_load;
  logic                   r_frame_start;
  logic                   r_frame_done;

  logic [1:0]    w_nxt_state;
  logic [RW-1:0] w_nxt_row;
  logic          w_nxt_phase;
  logic          w_latch;
  logic          w_cnt_inc;
  logic          w_cfg_err;
  logic          w_fs;
  logic          w_fd;
  logic          w_last;
  logic [EW-1:0] w_row_p2;
  logic [EW-1:0] w_first_p1;
  logic [EW-1:0] w_last_ext;

  // Row+2 and first+1 are compared one bit wider so the top row never wraps to 0
  always_comb begin
    w_row_p2   = {1'b0, r_row} + EW'(2);
    w_first_p1 = {1'b0, r_first} + EW'(1);
    w_last_ext = {1'b0, r_last};
    if (r_il) begin
      w_last = (w_row_p2 > w_last_ext) && (r_phase || (w_first_p1 > w_last_ext));
    end else begin
      w_last = (r_row == r_last);
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_row   = r_row;
    w_nxt_phase = r_phase;
    w_latch     = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cfg_err   = 1'b0;
    w_fs        = 1'b0;
    w_fd        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ctrl_go) begin
          if (cfg_row_first <= cfg_row_last) begin
            w_latch     = 1'b1;
            w_nxt_row   = cfg_row_first;
            w_nxt_phase = 1'b0;
            w_nxt_state = S_LOAD;
            w_fs        = 1'b1;
          end else begin
            w_cfg_err = 1'b1;
          end
        end
      end
      S_LOAD: w_nxt_state = S_WAIT;
      S_WAIT: begin
        if (bcm_rdy && fb_row_rdy) begin
          w_nxt_state = S_PAINT;
          w_fd        = w_last;
        end
      end
      S_PAINT: begin
        if (w_last) begin
          w_cnt_inc = 1'b1;
          if (r_loop && !r_stop_pend && !ctrl_stop) begin
            w_nxt_row   = r_first;
            w_nxt_phase = 1'b0;
            w_nxt_state = S_LOAD;
            w_fs        = 1'b1;
          end else begin
            w_nxt_state = S_IDLE;
          end
        end else begin
          w_nxt_state = S_LOAD;
          if (!r_il) begin
            w_nxt_row = r_row + RW'(1);
          end else if (!r_phase && (w_row_p2 > w_last_ext)) begin
            w_nxt_row   = RW'(w_first_p1);
            w_nxt_phase = 1'b1;
          end else begin
            w_nxt_row = RW'(w_row_p2);
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // State, latched config and registered strobes decoded from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_row         <= '0;
      r_phase       <= 1'b0;
      r_first       <= '0;
      r_last        <= '0;
      r_il          <= 1'b0;
      r_loop        <= 1'b0;
      r_stop_pend   <= 1'b0;
      r_frame_cnt   <= '0;
      r_ctrl_rdy    <= 1'b1;
      r_cfg_err     <= 1'b0;
      r_bcm_go      <= 1'b0;
      r_fb_load     <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_row   <= w_nxt_row;
      r_phase <= w_nxt_phase;
      if (w_latch) begin
        r_first <= cfg_row_first;
        r_last  <= cfg_row_last;
        r_il    <= cfg_interleave;
        r_loop  <= cfg_loop;
      end
      if (r_state == S_IDLE) begin
        r_stop_pend <= 1'b0;
      end else if (ctrl_stop) begin
        r_stop_pend <= 1'b1;
      end
      if (w_latch) begin
        r_frame_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      end
      r_ctrl_rdy    <= (w_nxt_state == S_IDLE);
      r_cfg_err     <= w_cfg_err;
      r_bcm_go      <= (w_nxt_state == S_PAINT);
      r_fb_load     <= (w_nxt_state == S_LOAD);
      r_frame_start <= w_fs;
      r_frame_done  <= w_fd;
    end
  end

  assign ctrl_rdy    = r_ctrl_rdy;
  assign cfg_err     = r_cfg_err;
  assign bcm_row     = r_row;
  assign bcm_go      = r_bcm_go;
  assign fb_row_addr = r_row;
  assign fb_row_load = r_fb_load;
  assign fb_row_swap = r_bcm_go;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench for hub75_scan_ctrl: directed scans push expected load/paint rows,
// a negedge monitor pops and compares whenever the DUT strobes a load or paint.
module tb_hub75_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] cfg_row_first;
  logic [4:0] cfg_row_last;
  logic       cfg_interleave;
  logic       cfg_loop;
  logic       ctrl_go;
  logic       ctrl_stop;
  logic       ctrl_rdy;
  logic       cfg_err;
  logic [4:0] bcm_row;
  logic       bcm_go;
  logic       bcm_rdy;
  logic [4:0] fb_row_addr;
  logic       fb_row_load;
  logic       fb_row_rdy;
  logic       fb_row_swap;
  logic       frame_start;
  logic       frame_done;
  logic [7:0] frame_cnt;

  hub75_scan_ctrl #(.N_ROWS(32), .FRAME_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_row_first(cfg_row_first), .cfg_row_last(cfg_row_last),
    .cfg_interleave(cfg_interleave), .cfg_loop(cfg_loop),
    .ctrl_go(ctrl_go), .ctrl_stop(ctrl_stop), .ctrl_rdy(ctrl_rdy), .cfg_err(cfg_err),
    .bcm_row(bcm_row), .bcm_go(bcm_go), .bcm_rdy(bcm_rdy),
    .fb_row_addr(fb_row_addr), .fb_row_load(fb_row_load), .fb_row_rdy(fb_row_rdy),
    .fb_row_swap(fb_row_swap), .frame_start(frame_start), .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int flag;
  } exp_t;

  exp_t q_load[$];
  exp_t q_paint[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   load_cnt = 0;
  int   paint_cnt = 0;
  int   fs_cnt = 0;
  int   done_cyc = 0;
  int   last_paint_cyc = -1;
  bit   gap_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int row, input int fs, input int fd);
    exp_t e;
    e.row = row; e.flag = fs; q_load.push_back(e);
    e.flag = fd; q_paint.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every load and paint strobe
  always @(negedge clk) begin
    exp_t e;
    if (fb_row_load) begin
      load_cnt++;
      if (frame_start) fs_cnt++;
      if (q_load.size() == 0) begin
        chk("load_unexpected", int'(fb_row_addr), -1);
      end else begin
        e = q_load.pop_front();
        chk("load_addr", int'(fb_row_addr), e.row);
        chk("load_frame_start", int'(frame_start), e.flag);
      end
    end else if (frame_start) begin
      chk("frame_start_without_load", 1, 0);
    end
    if (bcm_go) begin
      paint_cnt++;
      if (frame_done) done_cyc = cyc;
      chk("paint_swap", int'(fb_row_swap), 1);
      if (gap_chk && last_paint_cyc >= 0) chk("paint_gap", cyc - last_paint_cyc, 3);
      last_paint_cyc = cyc;
      if (q_paint.size() == 0) begin
        chk("paint_unexpected", int'(bcm_row), -1);
      end else begin
        e = q_paint.pop_front();
        chk("paint_row", int'(bcm_row), e.row);
        chk("paint_frame_done", int'(frame_done), e.flag);
      end
    end else if (fb_row_swap || frame_done) begin
      chk("swap_or_done_without_paint", 1, 0);
    end
  end

  task automatic do_go(input int f, input int l, input bit il, input bit lp);
    @(posedge clk); #1;
    cfg_row_first = 5'(f); cfg_row_last = 5'(l);
    cfg_interleave = il; cfg_loop = lp; ctrl_go = 1'b1;
    @(posedge clk); #1;
    ctrl_go = 1'b0;
    // Scrambled config afterwards must not affect the running scan
    cfg_row_first = 5'd31; cfg_row_last = 5'd0; cfg_interleave = ~il; cfg_loop = ~lp;
  endtask

  task automatic wait_idle(input int budget, output int idle_cyc);
    bit ok = 1'b0;
    idle_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ctrl_rdy && q_load.size() == 0 && q_paint.size() == 0) begin
        ok = 1'b1;
        idle_cyc = cyc;
        break;
      end
    end
    chk("idle_reached", int'(ok), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_idle;
    int base;
    int hits;
    bit seen;
    rst_n = 1'b0; ctrl_go = 1'b0; ctrl_stop = 1'b0;
    cfg_row_first = '0; cfg_row_last = '0; cfg_interleave = 1'b0; cfg_loop = 1'b0;
    bcm_rdy = 1'b1; fb_row_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ctrl_rdy", int'(ctrl_rdy), 1);
    chk("rst_bcm_go", int'(bcm_go), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_bcm_row", int'(bcm_row), 0);

    // Full linear window, single frame, 3-cycle row spacing
    for (int r = 0; r < 32; r++) push(r, (r == 0) ? 1 : 0, (r == 31) ? 1 : 0);
    base = paint_cnt; gap_chk = 1'b1; last_paint_cyc = -1;
    do_go(0, 31, 1'b0, 1'b0);
    wait_idle(200, t_idle);
    gap_chk = 1'b0;
    chk("lin_paints", paint_cnt - base, 32);
    chk("lin_rdy_after_done", t_idle - done_cyc, 1);
    chk("lin_frame_cnt", int'(frame_cnt), 1);

    // Interleaved windows
    push(3, 1, 0); push(5, 0, 0); push(7, 0, 0); push(4, 0, 0); push(6, 0, 0); push(8, 0, 1);
    do_go(3, 8, 1'b1, 1'b0);
    wait_idle(100, t_idle);
    chk("il38_frame_cnt", int'(frame_cnt), 1);
    push(28, 1, 0); push(30, 0, 0); push(29, 0, 0); push(31, 0, 1);
    do_go(28, 31, 1'b1, 1'b0);
    wait_idle(100, t_idle);

    // Single-row window, then a rejected window
    push(5, 1, 1);
    do_go(5, 5, 1'b0, 1'b0);
    wait_idle(50, t_idle);
    base = load_cnt;
    do_go(6, 2, 1'b0, 1'b0);
    @(negedge clk);
    chk("err_pulse", int'(cfg_err), 1);
    chk("err_ctrl_rdy", int'(ctrl_rdy), 1);
    @(negedge clk);
    chk("err_pulse_end", int'(cfg_err), 0);
    repeat (5) @(negedge clk);
    chk("err_no_load", load_cnt - base, 0);
    chk("err_ctrl_rdy_hold", int'(ctrl_rdy), 1);

    // Looping scan stopped during frame 2 row 1
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 4; r++) push(r, (r == 0) ? 1 : 0, (r == 3) ? 1 : 0);
    base = fs_cnt; hits = 0; seen = 1'b0;
    do_go(0, 3, 1'b0, 1'b1);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (fb_row_load && fb_row_addr == 5'd1) hits++;
      if (hits == 2) seen = 1'b1;
    end
    chk("stop_point_found", int'(seen), 1);
    ctrl_stop = 1'b1;
    @(posedge clk); #1 ctrl_stop = 1'b0;
    wait_idle(100, t_idle);
    chk("stop_frame_cnt", int'(frame_cnt), 2);
    chk("stop_frame_starts", fs_cnt - base, 2);

    // Stall in WAIT with only the BCM ready
    push(10, 1, 1);
    base = paint_cnt;
    fb_row_rdy = 1'b0;
    do_go(10, 10, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("stall_no_paint", paint_cnt - base, 0);
    fb_row_rdy = 1'b1;
    @(negedge clk);
    chk("stall_pre_edge", int'(bcm_go), 0);
    @(negedge clk);
    chk("stall_paint", int'(bcm_go), 1);
    wait_idle(20, t_idle);

    // Reset during the second-frame PAINT of row 7
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 8; r++) push(r, (r == 0) ? 1 : 0, (r == 7) ? 1 : 0);
    hits = 0; seen = 1'b0;
    do_go(0, 7, 1'b0, 1'b1);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bcm_go && bcm_row == 5'd7) hits++;
      if (hits == 2) seen = 1'b1;
    end
    chk("rst_point_found", int'(seen), 1);
    chk("pre_rst_frame_cnt", int'(frame_cnt), 1);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ctrl_rdy", int'(ctrl_rdy), 1);
    chk("midrst_bcm_row", int'(bcm_row), 0);
    chk("midrst_bcm_go", int'(bcm_go), 0);
    chk("midrst_load", int'(fb_row_load), 0);
    chk("midrst_frame_done", int'(frame_done), 0);
    chk("midrst_frame_cnt", int'(frame_cnt), 0);
    repeat (4) @(negedge clk);
    chk("midrst_queues_empty", q_load.size() + q_paint.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
